rst_handshake_gen: RTL and testbench

- Reset-issuing end of a reset domain crossing. Lives in the `clk` domain and drives an active-low reset `rst_out_n` into a far (downstream) domain.
- The far domain synchronises `rst_out_n` with its own reset synchroniser (async assert, sync deassert). It returns its synchronised reset state on `rst_ack`.
- This block enforces a minimum assert width and confirms the far domain entered reset, then released reset. A timeout guards both waits.
- Sequencing runs automatically after power-on and again on each software request.

---
 rtl/rst_pkg.sv | 17 +
 rtl/sync_bit.sv | 24 ++
 rtl/rst_handshake_gen.sv | 103 ++++++++++
 tb/tb_rst_handshake_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types and default constants for the reset handshake generator and
// anything else that talks to its reset domain crossing.
package rst_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        WAIT_HI = 3'd2,
        RELEASE = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int RST_SYNC_STAGES = 2;
    localparam int RST_MIN_ASSERT  = 8;
    localparam int RST_TIMEOUT     = 256;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with async active-low reset to a chosen value.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_handshake_gen.sv
// Issues an active-low reset into a far domain, holds it for a minimum width,
// then confirms the far domain entered and left reset, with a timeout on each wait.
module rst_handshake_gen
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES = RST_SYNC_STAGES,
    parameter int MIN_ASSERT  = RST_MIN_ASSERT,
    parameter int TIMEOUT     = RST_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw_rst_req,
    input  logic rst_ack,
    output logic rst_out_n,
    output logic ready,
    output logic done,
    output logic err
);

    localparam int CNT_MAX = (MIN_ASSERT > TIMEOUT) ? MIN_ASSERT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             done_nxt;
    logic             ack_s;

    // Reset value 1 so a power-on reset looks like the far domain is already held.
    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rst_ack),
        .q    (ack_s)
    );

    always_comb begin
        state_nxt = state;
        count_nxt = count + CNT_W'(1);
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (sw_rst_req) state_nxt = ASSERT;
            end
            ASSERT: begin
                if (count == ASSERT_LAST) begin
                    state_nxt = WAIT_HI;
                    count_nxt = '0;
                end
            end
            WAIT_HI: begin
                // Ack takes priority over a coincident timeout.
                if (ack_s) begin
                    state_nxt = RELEASE;
                    count_nxt = '0;
                end else if (count == TIMEOUT_LAST) begin
                    state_nxt = ERR;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (count == TIMEOUT_LAST) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                count_nxt = '0;
                if (sw_rst_req) state_nxt = ASSERT;
            end
            default: begin
                state_nxt = ASSERT;
                count_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ASSERT;
            count     <= '0;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            rst_out_n <= (state_nxt == IDLE) || (state_nxt == RELEASE);
            ready     <= (state_nxt == IDLE);
            done      <= done_nxt;
            err       <= (state_nxt == ERR);
        end
    end

endmodule

// File: tb/tb_rst_handshake_gen.sv
// Randomized bench: a far-domain reset synchroniser with random release lag drives
// rst_ack, and expected output timelines are computed from the handshake timing rules.
module tb_rst_handshake_gen;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_ASSERT  = 8;
    localparam int TIMEOUT     = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sw_rst_req = 1'b0;
    logic rst_ack;
    logic rst_out_n, ready, done, err;

    // Far domain: async assert, sync deassert after `lag` cycles; mode 0 follow, 1 tie 0, 2 tie 1.
    logic [7:0] far = 8'hFF;
    int lag = 3;
    int mode = 0;

    int vectors = 0;
    int miscompares = 0;

    rst_handshake_gen #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_ASSERT  (MIN_ASSERT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_rst_req (sw_rst_req),
        .rst_ack    (rst_ack),
        .rst_out_n  (rst_out_n),
        .ready      (ready),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_out_n) begin
        if (!rst_out_n) far <= 8'hFF;
        else            far <= {far[6:0], 1'b0};
    end

    assign rst_ack = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : far[lag-1];

    // Edge at which the block releases the far domain, and edge at which done pulses,
    // counted from the edge that started the sequence.
    function automatic int release_edge();
        return (MIN_ASSERT + 1 > SYNC_STAGES + 1) ? MIN_ASSERT + 1 : SYNC_STAGES + 1;
    endfunction

    function automatic int done_edge(int l);
        return release_edge() + l + SYNC_STAGES + 1;
    endfunction

    // Caller sits at the negedge just after edge 0 of a sequence.
    task automatic check_sequence(string name, bit inject);
        logic [3:0] exp, got;
        int r, d;
        r = release_edge();
        d = done_edge(lag);
        for (int e = 1; e <= d + 2; e++) begin
            sw_rst_req = (inject && e <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            exp = {e >= r, e >= d, e == d, 1'b0};
            got = {rst_out_n, ready, done, err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL %s lag=%0d cycle %0d: {rst_out_n,ready,done,err} got %b expected %b",
                         name, lag, e, got, exp);
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic issue_request(string name);
        logic [3:0] got;
        sw_rst_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_rst_req = 1'b0;
        got = {rst_out_n, ready, done, err};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL %s request edge: {rst_out_n,ready,done,err} got %b expected 0000",
                     name, got);
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        mode = 0;
        lag  = 3;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        got = {rst_out_n, ready, done, err};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %b expected 0000", got);
        end
        rstn = 1'b1;
        check_sequence("power_on", 1'b0);
    endtask

    task automatic test_request_sequences();
        for (int i = 0; i < 5; i++) begin
            lag = $urandom_range(1, 6);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            issue_request("request");
            check_sequence("request", 1'b0);
        end
    endtask

    task automatic test_ignored_requests();
        for (int i = 0; i < 4; i++) begin
            lag = $urandom_range(1, 6);
            issue_request("ignored_req");
            check_sequence("ignored_req", 1'b1);
        end
    endtask

    task automatic test_wait_hi_timeout();
        logic [3:0] exp, got;
        int t;
        mode = 1;
        t = MIN_ASSERT + TIMEOUT;
        issue_request("wait_hi_timeout");
        for (int e = 1; e <= t + 2 + int'($urandom_range(0, 6)); e++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {1'b0, 1'b0, 1'b0, e >= t};
            got = {rst_out_n, ready, done, err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL wait_hi_timeout cycle %0d: got %b expected %b", e, got, exp);
            end
        end
        mode = 0;
        lag  = $urandom_range(1, 6);
        issue_request("err_recover");
        check_sequence("err_recover", 1'b0);
    endtask

    task automatic test_release_timeout();
        logic [3:0] exp, got;
        int r, t;
        mode = 2;
        r = release_edge();
        t = r + TIMEOUT;
        issue_request("release_timeout");
        for (int e = 1; e <= t + 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp = {(e >= r) && (e < t), 1'b0, 1'b0, e >= t};
            got = {rst_out_n, ready, done, err};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL release_timeout cycle %0d: got %b expected %b", e, got, exp);
            end
        end
        mode = 0;
        lag  = $urandom_range(1, 6);
        issue_request("release_recover");
        check_sequence("release_recover", 1'b0);
    endtask

    task automatic test_midseq_reset();
        logic [3:0] got;
        lag = $urandom_range(2, 6);
        issue_request("midseq_reset");
        repeat (release_edge() + 1) @(posedge clk);
        #2;
        got = {rst_out_n, ready, done, err};
        vectors++;
        if (got !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL midseq_in_release: got %b expected 1000", got);
        end
        rstn = 1'b0;
        #1;
        got = {rst_out_n, ready, done, err};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midseq_async_assert: got %b expected 0000", got);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_sequence("after_midseq_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_request_sequences();
        test_ignored_requests();
        test_wait_hi_timeout();
        test_release_timeout();
        test_midseq_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
